// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : gmii_tx_framer
// Brief    : GMII byte-stream transmit framer: preamble/SFD, minimum-size
//            padding, CRC-32 FCS, inter-frame gap and underrun abort.
// Revision : 1.0 - initial release
// ============================================================================
module gmii_tx_framer #(
    parameter int min_frame_p = 60,
    parameter int ifg_bytes_p = 12
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       v_i,
    input  logic       last_i,
    output logic       ready_and_o,
    output logic [7:0] gmii_txd_o,
    output logic       gmii_tx_en_o,
    output logic       gmii_tx_er_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PREAMBLE = 4'd1,
        ST_SFD      = 4'd2,
        ST_DATA     = 4'd3,
        ST_PAD      = 4'd4,
        ST_FCS      = 4'd5,
        ST_ABORT    = 4'd6,
        ST_DRAIN    = 4'd7,
        ST_IFG      = 4'd8
    } state_t;

    localparam logic [10:0] c_min       = 11'(min_frame_p);
    localparam logic [15:0] c_ifg_last  = 16'((ifg_bytes_p > 0) ? ifg_bytes_p - 1 : 0);
    localparam state_t      c_post      = (ifg_bytes_p > 0) ? ST_IFG : ST_IDLE;
    localparam logic [31:0] c_crc_init  = 32'hFFFF_FFFF;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [10:0] r_byte_cnt, w_byte_cnt_nxt, w_byte_inc;
    logic [31:0] r_crc, w_crc_nxt, w_fcs;
    logic [7:0]  r_txd, w_txd_nxt;
    logic        r_tx_en, w_tx_en_nxt;
    logic        r_tx_er, w_tx_er_nxt;
    logic        r_done, w_done_nxt;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_byte_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
    assign w_fcs      = ~r_crc;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_crc_nxt      = r_crc;
        w_txd_nxt      = 8'h00;
        w_tx_en_nxt    = 1'b0;
        w_tx_er_nxt    = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (v_i) begin
                    w_state_nxt = ST_PREAMBLE;
                    w_cnt_nxt   = 16'd0;
                end
            end
            ST_PREAMBLE: begin
                w_txd_nxt   = 8'h55;
                w_tx_en_nxt = 1'b1;
                if (r_cnt == 16'd6) begin
                    w_state_nxt = ST_SFD;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_SFD: begin
                w_txd_nxt      = 8'hD5;
                w_tx_en_nxt    = 1'b1;
                w_state_nxt    = ST_DATA;
                w_byte_cnt_nxt = 11'd0;
                w_crc_nxt      = c_crc_init;
            end
            ST_DATA: begin
                w_tx_en_nxt = 1'b1;
                if (v_i) begin
                    w_txd_nxt      = data_i;
                    w_byte_cnt_nxt = w_byte_inc;
                    w_crc_nxt      = crc32_byte(r_crc, data_i);
                    if (last_i) begin
                        w_cnt_nxt   = 16'd0;
                        w_state_nxt = (w_byte_inc < c_min) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    // Underrun: the frame is corrupted on the wire and the rest is drained.
                    w_tx_er_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_ABORT;
                end
            end
            ST_PAD: begin
                w_tx_en_nxt    = 1'b1;
                w_byte_cnt_nxt = w_byte_inc;
                w_crc_nxt      = crc32_byte(r_crc, 8'h00);
                if (w_byte_inc >= c_min) begin
                    w_state_nxt = ST_FCS;
                    w_cnt_nxt   = 16'd0;
                end
            end
            ST_FCS: begin
                w_tx_en_nxt = 1'b1;
                w_txd_nxt   = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
                if (r_cnt[1:0] == 2'd3) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_post;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_ABORT: begin
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (v_i && last_i) begin
                    w_state_nxt = c_post;
                    w_cnt_nxt   = 16'd0;
                end
            end
            ST_IFG: begin
                if (r_cnt == c_ifg_last) begin
                    w_state_nxt = v_i ? ST_PREAMBLE : ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 16'd0;
            r_byte_cnt <= 11'd0;
            r_crc      <= c_crc_init;
            r_txd      <= 8'h00;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_crc      <= w_crc_nxt;
            r_txd      <= w_txd_nxt;
            r_tx_en    <= w_tx_en_nxt;
            r_tx_er    <= w_tx_er_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign ready_and_o  = ~reset_i & ((r_state == ST_DATA) | (r_state == ST_DRAIN));
    assign busy_o       = ~reset_i & (r_state != ST_IDLE);
    assign gmii_txd_o   = r_txd;
    assign gmii_tx_en_o = r_tx_en;
    assign gmii_tx_er_o = r_tx_er;
    assign frame_done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmii_tx_framer
// Brief    : Directed self-checking bench for gmii_tx_framer (padded and
//            unpadded instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_framer;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [7:0] data_i;
    logic       v_i, last_i, sel;

    logic       a_ready, a_en, a_er, a_busy, a_done;
    logic [7:0] a_txd;
    logic       b_ready, b_en, b_er, b_busy, b_done;
    logic [7:0] b_txd;
    logic       w_va, w_vb;
    logic       m_ready, m_en, m_er, m_busy, m_done;
    logic [7:0] m_txd;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_buf [64];
    logic [8:0] exp_q[$];
    logic [8:0] cap[$];
    int         done_pos[$];
    int         gaps[$];
    int         idle_run = 0;
    logic       prev_en = 1'b0;

    assign w_va = v_i & ~sel;
    assign w_vb = v_i & sel;

    gmii_tx_framer u_dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(w_va), .last_i(last_i),
        .ready_and_o(a_ready), .gmii_txd_o(a_txd), .gmii_tx_en_o(a_en),
        .gmii_tx_er_o(a_er), .busy_o(a_busy), .frame_done_o(a_done)
    );

    gmii_tx_framer #(.min_frame_p(0), .ifg_bytes_p(12)) u_nopad (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(w_vb), .last_i(last_i),
        .ready_and_o(b_ready), .gmii_txd_o(b_txd), .gmii_tx_en_o(b_en),
        .gmii_tx_er_o(b_er), .busy_o(b_busy), .frame_done_o(b_done)
    );

    assign m_ready = sel ? b_ready : a_ready;
    assign m_en    = sel ? b_en    : a_en;
    assign m_er    = sel ? b_er    : a_er;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_txd   = sel ? b_txd   : a_txd;

    always #4 clk = ~clk;

    // Wire monitor: every enabled byte, done positions and idle gap before each frame.
    always @(negedge clk) begin
        if (m_en) begin
            cap.push_back({m_er, m_txd});
            if (!prev_en) gaps.push_back(idle_run);
            idle_run <= 0;
        end else begin
            idle_run <= idle_run + 1;
        end
        if (m_done) done_pos.push_back(m_en ? cap.size() : -1);
        prev_en <= m_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    task automatic build_exp(input int n, input int min_len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        repeat (7) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, tx_buf[i]});
            c = crc_step(c, tx_buf[i]);
        end
        for (int i = n; i < min_len; i++) begin
            exp_q.push_back(9'h000);
            c = crc_step(c, 8'h00);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, c[8*i +: 8]});
    endtask

    task automatic compare_frame(input string tag, input int base);
        logic [8:0] got;
        check({tag, "_len"}, 32'(cap.size() - base), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            got = (base + i < cap.size()) ? cap[base + i] : 9'h1FF;
            check($sformatf("%s_b%0d", tag, i), 32'(got), 32'(exp_q[i]));
        end
    endtask

    // Presents n bytes honouring ready; optional one-cycle stall or reset at byte index.
    task automatic send(input int n, input int stall_at, input int rst_at,
                        output int acc, output int waits);
        int i     = 0;
        int guard = 0;
        bit stalled = 1'b0;
        waits = 0;
        while (i < n && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (i == rst_at) begin
                reset_i = 1'b1;
                v_i     = 1'b1;
                data_i  = tx_buf[i];
                last_i  = 1'b0;
                break;
            end
            if (i == stall_at && !stalled && m_ready) begin
                v_i     = 1'b0;
                last_i  = 1'b0;
                stalled = 1'b1;
            end else begin
                v_i    = 1'b1;
                data_i = tx_buf[i];
                last_i = (i == n - 1);
                if (m_ready) i++;
                else waits++;
            end
        end
        check("send_bound", 32'(guard < 5000), 32'd1);
        acc = i;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        @(negedge clk);
        while (m_busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(m_busy), 32'd0);
    endtask

    initial begin
        int acc, waits, cb, db, gb, n;
        reset_i = 1'b1; v_i = 1'b0; last_i = 1'b0; data_i = 8'h00; sel = 1'b0;
        repeat (3) @(negedge clk);
        v_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_txd",   32'(a_txd),   32'd0);
        check("rst_en",    32'(a_en),    32'd0);
        check("rst_er",    32'(a_er),    32'd0);
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_busy",  32'(a_busy),  32'd0);
        check("rst_done",  32'(a_done),  32'd0);
        check("rst_b_en",  32'(b_en),    32'd0);
        check("rst_b_bsy", 32'(b_busy),  32'd0);
        v_i = 1'b0; reset_i = 1'b0;
        @(negedge clk);

        // "123456789" without padding: known CRC-32 0xCBF43926.
        sel = 1'b1;
        for (int i = 0; i < 9; i++) tx_buf[i] = 8'h31 + 8'(i);
        exp_q = {};
        repeat (7) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, tx_buf[i]});
        exp_q.push_back(9'h026); exp_q.push_back(9'h039);
        exp_q.push_back(9'h0F4); exp_q.push_back(9'h0CB);
        cb = cap.size(); db = done_pos.size();
        send(9, -1, -1, acc, waits);
        check("t29_acc", 32'(acc), 32'd9);
        check("t29_wait", 32'(waits), 32'd9);
        @(negedge clk); v_i = 1'b0; last_i = 1'b0;
        wait_idle("t29_idle");
        compare_frame("t29", cb);
        check("t29_done_n", 32'(done_pos.size() - db), 32'd1);
        check("t29_done_at", 32'((done_pos.size() > db) ? done_pos[db] - 1 - cb : -1), 32'd20);

        // Padded 1-byte frame followed by a frame held off through the gap.
        sel = 1'b0;
        @(negedge clk);
        tx_buf[0] = 8'hAA;
        exp_q = {};
        build_exp(1, 60);
        cb = cap.size(); db = done_pos.size(); gb = gaps.size();
        send(1, -1, -1, acc, waits);
        check("t30_wait", 32'(waits), 32'd9);
        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
        build_exp(3, 60);
        send(3, -1, -1, acc, waits);
        check("t32_acc", 32'(acc), 32'd3);
        check("t32_wait", 32'(waits), 32'd83);
        @(negedge clk); v_i = 1'b0; last_i = 1'b0;
        wait_idle("t32_idle");
        compare_frame("t30", cb);
        check("t30_done_n", 32'(done_pos.size() - db), 32'd2);
        check("t30_done_at", 32'((done_pos.size() > db) ? done_pos[db] - 1 - cb : -1), 32'd71);
        check("t32_done_at", 32'((done_pos.size() > db + 1) ? done_pos[db + 1] - 1 - cb : -1), 32'd143);
        check("t32_gap", 32'((gaps.size() > gb + 1) ? gaps[gb + 1] : -1), 32'd12);

        // Underrun after 5 of 20 bytes.
        for (int i = 0; i < 20; i++) tx_buf[i] = 8'h40 + 8'(i);
        exp_q = {};
        repeat (7) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, tx_buf[i]});
        exp_q.push_back(9'h100);
        cb = cap.size(); db = done_pos.size();
        send(20, 5, -1, acc, waits);
        check("t31_acc", 32'(acc), 32'd20);
        @(negedge clk); v_i = 1'b0; last_i = 1'b0;
        n = 0;
        while (m_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("t31_ifg", 32'(n), 32'd12);
        compare_frame("t31", cb);
        check("t31_done_n", 32'(done_pos.size() - db), 32'd1);
        check("t31_done_at", 32'((done_pos.size() > db) ? done_pos[db] - 1 - cb : -1), 32'd13);

        // Reset while presenting the 30th data byte, then a clean frame.
        for (int i = 0; i < 40; i++) tx_buf[i] = 8'h01 + 8'(i);
        cb = cap.size(); db = done_pos.size();
        send(40, -1, 29, acc, waits);
        check("t33_acc", 32'(acc), 32'd29);
        @(negedge clk);
        check("t33_en",    32'(a_en),    32'd0);
        check("t33_txd",   32'(a_txd),   32'd0);
        check("t33_er",    32'(a_er),    32'd0);
        check("t33_ready", 32'(a_ready), 32'd0);
        check("t33_busy",  32'(a_busy),  32'd0);
        check("t33_done",  32'(a_done),  32'd0);
        check("t33_bytes", 32'(cap.size() - cb), 32'd37);
        reset_i = 1'b0; v_i = 1'b0; last_i = 1'b0;
        @(negedge clk);
        check("t33_no_done", 32'(done_pos.size() - db), 32'd0);
        exp_q = {};
        build_exp(3, 60);
        cb = cap.size(); db = done_pos.size();
        send(3, -1, -1, acc, waits);
        @(negedge clk); v_i = 1'b0; last_i = 1'b0;
        wait_idle("t33_idle");
        compare_frame("t33", cb);
        check("t33_done_n", 32'(done_pos.size() - db), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
